forward_hazard_unit: RTL and testbench
======================================

Name: forward_hazard_unit

Overview:
- Generates the 2-bit operand selects that drive the EX-stage ALU operand multiplexers of the 5-stage pipelined CPU.
- Selects: 0 = register file, 1 = EX/MEM result, 2 = MEM/WB result.
- Detects load-use hazards and taken-branch redirects, and issues stall and flush controls to the PC, IF/ID and ID/EX registers.
- Keeps its own scoreboard of destination registers for the instructions in EX and MEM.

Parameters:
- REG_ADDR_W, 5, width of a register index.
- SEL_W, 2, width of each forwarding select; it matches the downstream mux select input.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- id_valid  input  1  the ID stage holds a real instruction.
- id_rs  input  REG_ADDR_W  source register A of the ID instruction.
- id_rt  input  REG_ADDR_W  source register B of the ID instruction.
- id_rs_used  input  1  the ID instruction reads rs.
- id_rt_used  input  1  the ID instruction reads rt.
- id_rd  input  REG_ADDR_W  destination register of the ID instruction.
- id_reg_write  input  1  the ID instruction writes id_rd.
- id_mem_to_reg  input  1  the ID instruction is a load.
- ex_branch_taken  input  1  the branch or jump in EX is taken; redirect now.
- fwd_a_sel  output  SEL_W  operand A mux select for the instruction in EX (registered).
- fwd_b_sel  output  SEL_W  operand B mux select for the instruction in EX (registered).
- stall  output  1  hold PC and IF/ID this cycle (combinational).
- ifid_flush  output  1  zero IF/ID at the next edge (combinational).
- idex_flush  output  1  insert a bubble into ID/EX at the next edge (combinational).

Behaviour:
- Reset (asynchronous, immediate):
  - fwd_a_sel = fwd_b_sel = 0; scoreboard cleared (all we = 0, rd = 0); FSM = RUN.
  - Combinational outputs evaluate to 0 while rst is high.
- Scoreboard registers: ex_rd/ex_we/ex_load and mem_rd/mem_we.
- Scoreboard update at each edge:
  - MEM entry <= EX entry.
  - EX entry <= ID instruction (rd, reg_write & id_valid, mem_to_reg & id_valid) if ID advances, else bubble (we = 0, load = 0).
  - A write to register 0 is stored with we = 0.
- Hazard detection (combinational):
  - Load-use match: ex_load & ex_we & ((id_rs_used & id_rs == ex_rd) | (id_rt_used & id_rt == ex_rd)) & id_valid & ex_rd != 0.
- FSM states:
  - RUN: load-use match and !ex_branch_taken -> stall = 1, idex_flush = 1, next state LU_STALL.
  - ex_branch_taken (in any state) -> ifid_flush = 1, idex_flush = 1, stall = 0, next state RUN. Branch overrides a load-use stall because the stalled instruction is on the wrong path.
  - LU_STALL: exactly one bubble has been inserted. The load is now in MEM, so stall = 0 and ID advances; return to RUN. A second match here is impossible and is treated as RUN.
- ID advances when !stall and !idex_flush.
- Forwarding selects (registered), computed at the edge where ID advances, for the instruction entering EX:
  - If src_used & src != 0 & ex_we & ex_rd == src -> 1 (the producer will be in MEM).
  - Else if src_used & src != 0 & mem_we & mem_rd == src -> 2 (the producer will be in WB).
  - Else 0.
  - When both entries match, EX wins because it is the younger producer.
  - If a bubble enters EX, both selects <= 0.
- The select value 3 is never driven.
- Register 0 is never forwarded.
- The register file is write-first, so WB-to-ID same-cycle reads need no bypass from this unit.
- The unit raises no stall for non-load RAW hazards; forwarding covers them.
- Reset asserted mid-stall: FSM returns to RUN and the scoreboard is cleared; the stalled instruction is re-fetched by the core reset.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined:
  - Adds outputs stall_cnt[31:0] and flush_cnt[31:0].
  - stall_cnt increments on each cycle with stall = 1; flush_cnt increments on each cycle with ifid_flush = 1.
  - Both counters wrap at 2^32, reset to 0 asynchronously, and increment only while rst is low.
- When not defined: the ports and counters are absent, and all other behaviour is identical.

Test Plan:
- add r3,r1,r2 then sub r4,r3,r5 -> at the sub EX cycle fwd_a_sel = 1, fwd_b_sel = 0, stall = 0.
- add r3,.. ; nop ; or r6,r3,r3 -> at the or EX cycle fwd_a_sel = fwd_b_sel = 2.
- lw r8,0(r1) then add r9,r8,r2 -> one cycle with stall = 1 and idex_flush = 1; the next cycle stall = 0; at the add EX cycle fwd_a_sel = 2.
- lw r8 in EX, the dependent add in ID, and ex_branch_taken = 1 on the same cycle -> stall = 0, ifid_flush = 1, idex_flush = 1, FSM = RUN; the next EX selects are 0.
- add r0,r1,r2 then sub r4,r0,r0 -> selects stay 0; add r5,.. twice then use r5 -> select 1 (the younger producer wins over 2).
- rst pulsed during LU_STALL -> selects are 0 immediately and stall is 0. With HAZARD_PERF_CNT_EN, 3 load-use stalls and 2 branches give stall_cnt = 3 and flush_cnt = 2.

Source files
------------

// File: rtl/forward_hazard_unit.sv
// ============================================================================
// forward_hazard_unit
//
// Purpose:
//   EX-stage operand forwarding and pipeline hazard control for the 5-stage
//   pipelined CPU. It tracks the destination registers of the instructions
//   now in EX and MEM in a small scoreboard. From that it produces:
//     - registered forwarding selects for the instruction entering EX
//       (0 = register file, 1 = EX/MEM result, 2 = MEM/WB result);
//     - combinational stall/flush controls for load-use hazards and
//       taken-branch redirects.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   id_valid                 ID stage holds a real instruction
//   id_rs, id_rt             source registers of the ID instruction
//   id_rs_used, id_rt_used   ID instruction actually reads rs / rt
//   id_rd                    destination register of the ID instruction
//   id_reg_write             ID instruction writes id_rd
//   id_mem_to_reg            ID instruction is a load
//   ex_branch_taken          branch/jump in EX is taken (redirect now)
//   fwd_a_sel, fwd_b_sel     operand A/B mux selects for EX (registered)
//   stall                    hold PC and IF/ID this cycle
//   ifid_flush               zero IF/ID at the next edge
//   idex_flush               bubble into ID/EX at the next edge
//   stall_cnt, flush_cnt     performance counters (HAZARD_PERF_CNT_EN only)
//
// Optional feature:
//   Define HAZARD_PERF_CNT_EN to add the 32-bit stall_cnt and flush_cnt
//   outputs. Without it the ports and counters are absent.
// ============================================================================
module forward_hazard_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int SEL_W      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_rs_used,
    input  logic                  id_rt_used,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_to_reg,
    input  logic                  ex_branch_taken,
    output logic [SEL_W-1:0]      fwd_a_sel,
    output logic [SEL_W-1:0]      fwd_b_sel,
    output logic                  stall,
    output logic                  ifid_flush,
    output logic                  idex_flush
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cnt,
    output logic [31:0]           flush_cnt
`endif
);

    localparam logic [SEL_W-1:0] SEL_RF    = SEL_W'(0);
    localparam logic [SEL_W-1:0] SEL_EXMEM = SEL_W'(1);
    localparam logic [SEL_W-1:0] SEL_MEMWB = SEL_W'(2);

    typedef enum logic {
        RUN      = 1'b0,
        LU_STALL = 1'b1
    } state_t;

    state_t                state;

    // Scoreboard: destination of the instruction in EX and in MEM.
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_we;
    logic                  ex_load;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic                  mem_we;

    logic                  load_use;
    logic                  id_advance;
    logic [SEL_W-1:0]      fwd_a_next;
    logic [SEL_W-1:0]      fwd_b_next;

    // ex_we is never set for r0, so a load into r0 cannot trigger a stall;
    // the explicit rd check keeps that true regardless of how we is loaded.
    assign load_use = id_valid && ex_load && ex_we && (ex_rd != '0) &&
                      ((id_rs_used && (id_rs == ex_rd)) ||
                       (id_rt_used && (id_rt == ex_rd)));

    // Hazard controls. A taken branch wins over a load-use stall because the
    // dependent instruction in ID is on the wrong path and gets flushed.
    always_comb begin
        stall      = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        if (!rst) begin
            if (ex_branch_taken) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (load_use) begin
                stall      = 1'b1;
                idex_flush = 1'b1;
            end
        end
    end

    assign id_advance = !stall && !idex_flush;

    // Selects for the instruction about to enter EX. The current EX entry
    // moves to MEM at the same edge, hence select 1; the MEM entry moves to
    // WB, hence select 2. The EX entry is the younger producer and wins.
    always_comb begin
        fwd_a_next = SEL_RF;
        if (id_rs_used && (id_rs != '0)) begin
            if (ex_we && (ex_rd == id_rs)) begin
                fwd_a_next = SEL_EXMEM;
            end else if (mem_we && (mem_rd == id_rs)) begin
                fwd_a_next = SEL_MEMWB;
            end
        end
    end

    always_comb begin
        fwd_b_next = SEL_RF;
        if (id_rt_used && (id_rt != '0)) begin
            if (ex_we && (ex_rd == id_rt)) begin
                fwd_b_next = SEL_EXMEM;
            end else if (mem_we && (mem_rd == id_rt)) begin
                fwd_b_next = SEL_MEMWB;
            end
        end
    end

    // FSM, scoreboard shift and registered forwarding selects.
    // LU_STALL marks the single bubble cycle of a load-use stall. By then the
    // load sits in MEM and EX holds the bubble, so no new match can arise; if
    // one did it would be handled exactly as in RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            ex_rd     <= '0;
            ex_we     <= 1'b0;
            ex_load   <= 1'b0;
            mem_rd    <= '0;
            mem_we    <= 1'b0;
            fwd_a_sel <= SEL_RF;
            fwd_b_sel <= SEL_RF;
        end else begin
            mem_rd <= ex_rd;
            mem_we <= ex_we;

            if (id_advance) begin
                ex_rd     <= id_rd;
                ex_we     <= id_reg_write && id_valid && (id_rd != '0);
                ex_load   <= id_mem_to_reg && id_valid;
                fwd_a_sel <= fwd_a_next;
                fwd_b_sel <= fwd_b_next;
            end else begin
                ex_rd     <= '0;
                ex_we     <= 1'b0;
                ex_load   <= 1'b0;
                fwd_a_sel <= SEL_RF;
                fwd_b_sel <= SEL_RF;
            end

            unique case (state)
                RUN: begin
                    state <= (!ex_branch_taken && load_use) ? LU_STALL : RUN;
                end
                LU_STALL: begin
                    state <= (!ex_branch_taken && load_use) ? LU_STALL : RUN;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // Free-running event counters; they wrap naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (ifid_flush) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_forward_hazard_unit.sv
// ============================================================================
// tb_forward_hazard_unit
//
// Self-checking bench for forward_hazard_unit. A table of hand-derived
// instruction sequences is followed by random traffic compared against a
// reference model that treats the pipeline as a queue of in-flight
// instructions, then reset-during-stall and performance-counter sequences
// (the counter checks exist only when HAZARD_PERF_CNT_EN is defined).
// ============================================================================
module tb_forward_hazard_unit;

    localparam int K_NOP = 0;
    localparam int K_ALU = 1;
    localparam int K_LD  = 2;
    localparam int K_INV = 3;

    typedef struct {
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       rs_used;
        logic       rt_used;
        logic [4:0] rd;
        logic       rw;
        logic       m2r;
        logic       br;
        logic       e_stall;
        logic       e_ifid;
        logic       e_idex;
        logic [1:0] e_a;
        logic [1:0] e_b;
    } vec_t;

    // One in-flight instruction as seen by the model.
    typedef struct {
        int rd;
        bit writes;
        bit load;
    } slot_t;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_rs_used;
    logic       id_rt_used;
    logic [4:0] id_rd;
    logic       id_reg_write;
    logic       id_mem_to_reg;
    logic       ex_branch_taken;
    logic [1:0] fwd_a_sel;
    logic [1:0] fwd_b_sel;
    logic       stall;
    logic       ifid_flush;
    logic       idex_flush;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    int n_compared;
    int n_mismatched;

    // Model: pipe[0] is the instruction in EX, pipe[1] the one in MEM.
    slot_t pipe[$];
    int    m_sel_a;
    int    m_sel_b;
    int    m_stall_cnt;
    int    m_flush_cnt;
    bit    m_stall;
    bit    m_ifid;
    bit    m_idex;

    vec_t  tbl[29];

    forward_hazard_unit #(
        .REG_ADDR_W(5),
        .SEL_W     (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid       (id_valid),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_rs_used     (id_rs_used),
        .id_rt_used     (id_rt_used),
        .id_rd          (id_rd),
        .id_reg_write   (id_reg_write),
        .id_mem_to_reg  (id_mem_to_reg),
        .ex_branch_taken(ex_branch_taken),
        .fwd_a_sel      (fwd_a_sel),
        .fwd_b_sel      (fwd_b_sel),
        .stall          (stall),
        .ifid_flush     (ifid_flush),
        .idex_flush     (idex_flush)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input int kind, input int rd, input int rs,
                                input int rt, input bit br, input bit es,
                                input bit ef, input bit ei, input int ea,
                                input int eb);
        vec_t v;
        v.valid   = (kind != K_INV);
        v.rs      = 5'(rs);
        v.rt      = 5'(rt);
        v.rs_used = (kind == K_ALU) || (kind == K_LD) || (kind == K_INV);
        v.rt_used = (kind == K_ALU) || (kind == K_INV);
        v.rd      = 5'(rd);
        v.rw      = (kind == K_ALU) || (kind == K_LD);
        v.m2r     = (kind == K_LD);
        v.br      = br;
        v.e_stall = es;
        v.e_ifid  = ef;
        v.e_idex  = ei;
        v.e_a     = 2'(ea);
        v.e_b     = 2'(eb);
        return v;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        v = mk(K_NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v.valid   = ($urandom_range(0, 7) != 0);
        v.rs      = 5'($urandom_range(0, 7));
        v.rt      = 5'($urandom_range(0, 7));
        v.rs_used = $urandom_range(0, 3) != 0;
        v.rt_used = $urandom_range(0, 1) != 0;
        v.rd      = 5'($urandom_range(0, 7));
        v.rw      = $urandom_range(0, 3) != 0;
        v.m2r     = $urandom_range(0, 2) == 0;
        v.br      = $urandom_range(0, 7) == 0;
        return v;
    endfunction

    function automatic void model_reset();
        slot_t bubble;
        bubble = '{rd: 0, writes: 1'b0, load: 1'b0};
        pipe.delete();
        pipe.push_back(bubble);
        pipe.push_back(bubble);
        m_sel_a     = 0;
        m_sel_b     = 0;
        m_stall_cnt = 0;
        m_flush_cnt = 0;
    endfunction

    // Nearest older in-flight writer of src: one ahead -> 1, two ahead -> 2.
    function automatic int producer_sel(input int src, input bit used);
        if (!used || src == 0) return 0;
        for (int k = 0; k < 2; k++) begin
            if (pipe[k].writes && pipe[k].rd == src) return k + 1;
        end
        return 0;
    endfunction

    function automatic void model_comb(input vec_t s);
        bit reads_load;
        reads_load = s.valid && pipe[0].load && pipe[0].writes &&
                     ((s.rs_used && s.rs == 5'(pipe[0].rd)) ||
                      (s.rt_used && s.rt == 5'(pipe[0].rd)));
        m_ifid  = s.br;
        m_stall = !s.br && reads_load;
        m_idex  = s.br || reads_load;
    endfunction

    function automatic void model_step(input vec_t s);
        slot_t nxt;
        model_comb(s);
        if (m_stall) m_stall_cnt++;
        if (m_ifid)  m_flush_cnt++;
        if (!m_stall && !m_idex) begin
            m_sel_a = producer_sel(int'(s.rs), s.rs_used);
            m_sel_b = producer_sel(int'(s.rt), s.rt_used);
            nxt = '{rd: int'(s.rd), writes: s.rw && s.valid && s.rd != 0,
                    load: s.m2r && s.valid};
        end else begin
            m_sel_a = 0;
            m_sel_b = 0;
            nxt = '{rd: 0, writes: 1'b0, load: 1'b0};
        end
        pipe.push_front(nxt);
        void'(pipe.pop_back());
    endfunction

    task automatic checkOutput(input string name, input int actual,
                               input int expected);
        n_compared++;
        if (actual != expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)",
                     name, actual, expected, $time);
        end
    endtask

    // Drive one ID-stage instruction and let the combinational paths settle.
    task automatic applyStimulus(input vec_t s);
        id_valid        = s.valid;
        id_rs           = s.rs;
        id_rt           = s.rt;
        id_rs_used      = s.rs_used;
        id_rt_used      = s.rt_used;
        id_rd           = s.rd;
        id_reg_write    = s.rw;
        id_mem_to_reg   = s.m2r;
        ex_branch_taken = s.br;
        #2;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAgainstModel(input string tag, input vec_t s);
        model_comb(s);
        checkOutput({tag, ".stall"},      int'(stall),      int'(m_stall));
        checkOutput({tag, ".ifid_flush"}, int'(ifid_flush), int'(m_ifid));
        checkOutput({tag, ".idex_flush"}, int'(idex_flush), int'(m_idex));
        checkOutput({tag, ".fwd_a"},      int'(fwd_a_sel),  m_sel_a);
        checkOutput({tag, ".fwd_b"},      int'(fwd_b_sel),  m_sel_b);
    endtask

    task automatic modelCycle(input string tag, input vec_t s);
        applyStimulus(s);
        checkAgainstModel(tag, s);
        model_step(s);
        nextCycle();
    endtask

    task automatic resetDut();
        rst = 1'b1;
        applyStimulus(mk(K_NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        model_reset();
        nextCycle();
        rst = 1'b0;
    endtask

    initial begin
        string tag;
        vec_t  v;
        n_compared   = 0;
        n_mismatched = 0;
        rst          = 1'b1;
        model_reset();

        // Reset state: combinational outputs low even with a branch request.
        applyStimulus(mk(K_ALU, 3, 1, 2, 1, 0, 0, 0, 0, 0));
        checkOutput("reset.stall",      int'(stall),      0);
        checkOutput("reset.ifid_flush", int'(ifid_flush), 0);
        checkOutput("reset.idex_flush", int'(idex_flush), 0);
        checkOutput("reset.fwd_a",      int'(fwd_a_sel),  0);
        checkOutput("reset.fwd_b",      int'(fwd_b_sel),  0);
        nextCycle();
        rst = 1'b0;

        // Instruction stream; expected selects belong to the instruction
        // issued on the previous row (now in EX).
        tbl[0]  = mk(K_ALU, 3, 1, 2,   0, 0, 0, 0, 0, 0); // add r3,r1,r2
        tbl[1]  = mk(K_ALU, 4, 3, 5,   0, 0, 0, 0, 0, 0); // sub r4,r3,r5
        tbl[2]  = mk(K_NOP, 0, 0, 0,   0, 0, 0, 0, 1, 0); // sub in EX
        tbl[3]  = mk(K_ALU, 3, 1, 2,   0, 0, 0, 0, 0, 0); // add r3
        tbl[4]  = mk(K_NOP, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        tbl[5]  = mk(K_ALU, 6, 3, 3,   0, 0, 0, 0, 0, 0); // or r6,r3,r3
        tbl[6]  = mk(K_NOP, 0, 0, 0,   0, 0, 0, 0, 2, 2); // or in EX
        tbl[7]  = mk(K_LD,  8, 1, 0,   0, 0, 0, 0, 0, 0); // lw r8,0(r1)
        tbl[8]  = mk(K_ALU, 9, 8, 2,   0, 1, 0, 1, 0, 0); // add r9: stall
        tbl[9]  = mk(K_ALU, 9, 8, 2,   0, 0, 0, 0, 0, 0); // bubble in EX
        tbl[10] = mk(K_NOP, 0, 0, 0,   0, 0, 0, 0, 2, 0); // add in EX
        tbl[11] = mk(K_LD,  8, 1, 0,   0, 0, 0, 0, 0, 0); // lw r8
        tbl[12] = mk(K_ALU, 9, 8, 2,   1, 0, 1, 1, 0, 0); // branch wins
        tbl[13] = mk(K_NOP, 0, 0, 0,   0, 0, 0, 0, 0, 0); // bubble in EX
        tbl[14] = mk(K_ALU, 0, 1, 2,   0, 0, 0, 0, 0, 0); // add r0,r1,r2
        tbl[15] = mk(K_ALU, 4, 0, 0,   0, 0, 0, 0, 0, 0); // sub r4,r0,r0
        tbl[16] = mk(K_ALU, 5, 1, 2,   0, 0, 0, 0, 0, 0); // add r5 ; sub 0/0
        tbl[17] = mk(K_ALU, 5, 1, 2,   0, 0, 0, 0, 0, 0); // add r5
        tbl[18] = mk(K_ALU, 7, 5, 5,   0, 0, 0, 0, 0, 0); // add r7,r5,r5
        tbl[19] = mk(K_NOP, 0, 0, 0,   0, 0, 0, 0, 1, 1); // younger wins
        tbl[20] = mk(K_LD, 10, 1, 0,   0, 0, 0, 0, 0, 0); // lw r10
        tbl[21] = mk(K_ALU, 11, 2, 10, 0, 1, 0, 1, 0, 0); // rt use: stall
        tbl[22] = mk(K_ALU, 11, 2, 10, 0, 0, 0, 0, 0, 0);
        tbl[23] = mk(K_NOP, 0, 0, 0,   0, 0, 0, 0, 0, 2); // sub in EX
        tbl[24] = mk(K_LD, 12, 1, 0,   0, 0, 0, 0, 0, 0); // lw r12
        tbl[25] = mk(K_INV, 0, 12, 0,  0, 0, 0, 0, 0, 0); // not valid: no stall
        tbl[26] = mk(K_LD,  0, 1, 0,   0, 0, 0, 0, 1, 0); // lw r0
        tbl[27] = mk(K_ALU, 1, 0, 0,   0, 0, 0, 0, 0, 0); // reads r0: no stall
        tbl[28] = mk(K_NOP, 0, 0, 0,   0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 29; i++) begin
            tag = $sformatf("vec%0d", i);
            applyStimulus(tbl[i]);
            checkOutput({tag, ".stall"},      int'(stall),      int'(tbl[i].e_stall));
            checkOutput({tag, ".ifid_flush"}, int'(ifid_flush), int'(tbl[i].e_ifid));
            checkOutput({tag, ".idex_flush"}, int'(idex_flush), int'(tbl[i].e_idex));
            checkOutput({tag, ".fwd_a"},      int'(fwd_a_sel),  int'(tbl[i].e_a));
            checkOutput({tag, ".fwd_b"},      int'(fwd_b_sel),  int'(tbl[i].e_b));
            model_step(tbl[i]);
            nextCycle();
        end

        // Random traffic over a small register set to provoke many matches.
        for (int i = 0; i < 400; i++) begin
            v = rand_vec();
            modelCycle($sformatf("rnd%0d", i), v);
        end

        // Reset asserted in the middle of a load-use stall.
        resetDut();
        modelCycle("rs.add", mk(K_ALU, 3, 1, 2, 0, 0, 0, 0, 0, 0));
        modelCycle("rs.lw",  mk(K_LD,  8, 3, 0, 0, 0, 0, 0, 0, 0));
        v = mk(K_ALU, 9, 8, 2, 0, 0, 0, 0, 0, 0);
        applyStimulus(v);
        checkOutput("rs.stall_before", int'(stall),     1);
        checkOutput("rs.fwd_a_before", int'(fwd_a_sel), 1);
        rst             = 1'b1;
        ex_branch_taken = 1'b1;
        #1;
        checkOutput("rs.fwd_a_in_reset",  int'(fwd_a_sel),  0);
        checkOutput("rs.fwd_b_in_reset",  int'(fwd_b_sel),  0);
        checkOutput("rs.stall_in_reset",  int'(stall),      0);
        checkOutput("rs.ifid_in_reset",   int'(ifid_flush), 0);
        checkOutput("rs.idex_in_reset",   int'(idex_flush), 0);
        model_reset();
        nextCycle();
        rst = 1'b0;
        modelCycle("rs.after", v);

        // Three load-use stalls and two taken branches from a clean reset.
        resetDut();
        for (int i = 0; i < 3; i++) begin
            modelCycle($sformatf("pc.lw%0d", i),   mk(K_LD,  8, 1, 0, 0, 0, 0, 0, 0, 0));
            modelCycle($sformatf("pc.use%0d", i),  mk(K_ALU, 9, 8, 2, 0, 0, 0, 0, 0, 0));
            modelCycle($sformatf("pc.held%0d", i), mk(K_ALU, 9, 8, 2, 0, 0, 0, 0, 0, 0));
        end
        for (int i = 0; i < 2; i++) begin
            modelCycle($sformatf("pc.br%0d", i), mk(K_NOP, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        end
        modelCycle("pc.tail", mk(K_NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0));
`ifdef HAZARD_PERF_CNT_EN
        checkOutput("stall_cnt", int'(stall_cnt), 3);
        checkOutput("flush_cnt", int'(flush_cnt), 2);
        checkOutput("stall_cnt.model", int'(stall_cnt), m_stall_cnt);
        checkOutput("flush_cnt.model", int'(flush_cnt), m_flush_cnt);
        rst = 1'b1;
        #1;
        checkOutput("stall_cnt.reset", int'(stall_cnt), 0);
        checkOutput("flush_cnt.reset", int'(flush_cnt), 0);
        nextCycle();
        rst = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_compared, n_mismatched);
        $finish;
    end

endmodule
